// File: rtl/simd_mem_access_unit_if.sv
// Request/response and dmem bus bundle for simd_mem_access_unit.
// The master side is the load/store path plus the RAM read data; the slave side is the unit.
interface simd_mem_access_unit_if #(
    parameter int unsigned ADDR_HI = 18
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic                 req_vec;
    logic [31:0]          req_addr;
    logic [255:0]         req_wdata;
    logic                 resp_valid;
    logic                 resp_err;
    logic [255:0]         resp_rdata;
    logic [ADDR_HI-5:0]   address_RAM;
    logic [31:0]          byteena_RAM;
    logic [255:0]         writeData_RAM;
    logic                 rden_RAM;
    logic                 wren_RAM;
    logic [255:0]         readData_RAM;

    modport master (
        output req_valid, req_we, req_vec, req_addr, req_wdata, readData_RAM,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM
    );

    modport slave (
        input  req_valid, req_we, req_vec, req_addr, req_wdata, readData_RAM,
        output req_ready, resp_valid, resp_err, resp_rdata,
               address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM
    );
endinterface

// File: rtl/simd_mem_access_unit.sv
// Memory-stage access controller: one scalar/vector load or store per transaction
// against a 256-bit dmem port with fixed read latency; one response per request.
module simd_mem_access_unit #(
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned ADDR_HI = 18
) (
    input logic                   clk,
    input logic                   reset,
    simd_mem_access_unit_if.slave mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic               we_q, we_nxt;
    logic               vec_q, vec_nxt;
    logic [2:0]         lane_q, lane_nxt;
    logic [1:0]         cnt_q, cnt_nxt;

    logic               ready_q;
    logic               resp_valid_q, resp_valid_nxt;
    logic               resp_err_q, resp_err_nxt;
    logic [255:0]       resp_rdata_q, resp_rdata_nxt;
    logic [ADDR_HI-5:0] addr_q, addr_nxt;
    logic [31:0]        be_q, be_nxt;
    logic [255:0]       wd_q, wd_nxt;
    logic               rden_q, rden_nxt;
    logic               wren_q, wren_nxt;

    logic               accept;
    logic               req_err;

    assign accept  = mem.req_valid & ready_q;
    assign req_err = (mem.req_vec && (mem.req_addr[4:0] != 5'd0)) ||
                     (!mem.req_vec && (mem.req_addr[1:0] != 2'd0)) ||
                     (mem.req_addr[31:ADDR_HI+1] != '0);

    // Outputs are registered from next-state values, so the strobe for an
    // accepted request is computed from the live request inputs in IDLE.
    always_comb begin
        state_nxt      = state;
        we_nxt         = we_q;
        vec_nxt        = vec_q;
        lane_nxt       = lane_q;
        cnt_nxt        = cnt_q;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = '0;
        addr_nxt       = '0;
        be_nxt         = '0;
        wd_nxt         = '0;
        rden_nxt       = 1'b0;
        wren_nxt       = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    we_nxt   = mem.req_we;
                    vec_nxt  = mem.req_vec;
                    lane_nxt = mem.req_addr[4:2];
                    if (req_err) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ACCESS;
                        addr_nxt  = mem.req_addr[ADDR_HI:5];
                        if (mem.req_we) begin
                            wren_nxt = 1'b1;
                            if (mem.req_vec) begin
                                be_nxt = '1;
                                wd_nxt = mem.req_wdata;
                            end else begin
                                be_nxt = 32'h0000_000F << {mem.req_addr[4:2], 2'b00};
                                wd_nxt = {8{mem.req_wdata[31:0]}};
                            end
                        end else begin
                            rden_nxt = 1'b1;
                            be_nxt   = '1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 2'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                    if (vec_q) resp_rdata_nxt = mem.readData_RAM;
                    else       resp_rdata_nxt = {224'b0, mem.readData_RAM[{lane_q, 5'b0} +: 32]};
                end else begin
                    cnt_nxt = cnt_q - 2'd1;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            vec_q        <= 1'b0;
            lane_q       <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wd_q         <= '0;
            rden_q       <= 1'b0;
            wren_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            we_q         <= we_nxt;
            vec_q        <= vec_nxt;
            lane_q       <= lane_nxt;
            cnt_q        <= cnt_nxt;
            ready_q      <= (state_nxt == IDLE);
            resp_valid_q <= resp_valid_nxt;
            resp_err_q   <= resp_err_nxt;
            resp_rdata_q <= resp_rdata_nxt;
            addr_q       <= addr_nxt;
            be_q         <= be_nxt;
            wd_q         <= wd_nxt;
            rden_q       <= rden_nxt;
            wren_q       <= wren_nxt;
        end
    end

    assign mem.req_ready     = ready_q;
    assign mem.resp_valid    = resp_valid_q;
    assign mem.resp_err      = resp_err_q;
    assign mem.resp_rdata    = resp_rdata_q;
    assign mem.address_RAM   = addr_q;
    assign mem.byteena_RAM   = be_q;
    assign mem.writeData_RAM = wd_q;
    assign mem.rden_RAM      = rden_q;
    assign mem.wren_RAM      = wren_q;
endmodule

// File: doc/simd_mem_access_unit.md
Name: simd_mem_access_unit

Overview:
- Memory-stage access controller between the simd_processor load/store path and the 256-bit dmem port.
- Accepts one scalar (32-bit) or vector (256-bit) load/store request per transaction and converts the byte address to a RAM word address.
- Generates byte enables and lane-replicated write data, sequences the RAM's fixed read latency, and returns one response per request.

Parameters:
- RD_LAT, 2, cycles from the rden_RAM cycle to the cycle in which readData_RAM is valid (1..4).
- ADDR_HI, 18, highest byte-address bit mapped into RAM. Address bits above it must be zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_vec  in  1  1 = 256-bit vector access, 0 = 32-bit scalar access.
- req_addr  in  32  byte address.
- req_wdata  in  256  store data; scalar stores use [31:0].
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  qualifies resp_valid: misaligned or out-of-range request, no RAM access made.
- resp_rdata  out  256  load data; scalar load zero-extended in [31:0]; 0 for stores and errors.
- address_RAM  out  14  RAM word address = req_addr[ADDR_HI:5].
- byteena_RAM  out  32  byte enables.
- writeData_RAM  out  256  RAM write data.
- rden_RAM  out  1  RAM read strobe.
- wren_RAM  out  1  RAM write strobe.
- readData_RAM  in  256  RAM read data.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0 during reset, 1 in the first cycle after reset deasserts. All other outputs = 0. State = IDLE.
- States: IDLE, ACCESS, WAIT, RESP.
- req_ready = 1 only in IDLE. Accept = req_valid & req_ready. Request fields are latched on accept.
- Error check on accept:
  - vector with req_addr[4:0] != 0, or
  - scalar with req_addr[1:0] != 0, or
  - req_addr[31:ADDR_HI+1] != 0.
  - On error: go directly to RESP with resp_err=1 and resp_rdata=0. No strobe is ever issued.
- IDLE -> ACCESS on a valid accept. In ACCESS, exactly one strobe cycle is driven:
  - address_RAM = latched addr[ADDR_HI:5]; lane = addr[4:2].
  - Vector store: byteena=32'hFFFF_FFFF, writeData_RAM=wdata, wren=1.
  - Scalar store: byteena=32'h0000_000F << (4*lane), writeData_RAM = wdata[31:0] replicated 8x, wren=1.
  - Any load: byteena=32'hFFFF_FFFF, rden=1, writeData_RAM=0.
- ACCESS -> RESP for stores. ACCESS -> WAIT for loads.
- WAIT: counter counts RD_LAT-1 cycles after the strobe cycle. In the cycle where readData_RAM is valid (strobe cycle + RD_LAT), capture it and go to RESP.
  - Vector load: resp_rdata = readData_RAM.
  - Scalar load: resp_rdata = {224'b0, readData_RAM[32*lane +: 32]}.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- In every state other than ACCESS: rden=wren=0, byteena=0, address=0, writeData=0.
- resp_rdata/resp_err hold their values only while resp_valid=1; otherwise they are 0.
- Latency, accept edge at cycle 0:
  - store: strobe in cycle 1, resp_valid in cycle 2, req_ready again in cycle 3.
  - load: strobe in cycle 1, data in cycle 1+RD_LAT, resp_valid in cycle 2+RD_LAT.
  - error: resp_valid in cycle 1.
- No response backpressure: the consumer must take the resp_valid pulse.
- req_valid asserted while req_ready=0 is ignored. The requester must hold the request until accepted.
- Reset in any state: the in-flight access is abandoned, the pending response is dropped, outputs return to 0 the next cycle, and no strobe is emitted after the reset cycle.
- Wrap: address_RAM spans the full 14-bit range (word 16383 = byte 0x7FFE0). No wrap; out-of-range requests are errors.

Test Plan:
- Vector store then load, addr 0x00000040, wdata = 256'h0123…EF pattern: address_RAM=2, byteena=FFFFFFFF, wren one cycle; load returns identical data with resp_valid at cycle 2+RD_LAT and resp_err=0.
- Scalar store 0xDEADBEEF to 0x0000004C: lane 3, byteena=32'h0000_F000, writeData all lanes 0xDEADBEEF. A scalar load of 0x4C returns resp_rdata=0x00000000_DEADBEEF (zero-extended). A vector load of 0x40 shows only lane 3 changed.
- Misaligned vector 0x44, misaligned scalar 0x42, out-of-range 0x00080000: each gives resp_valid+resp_err in cycle 1, rden/wren never asserted.
- Back-to-back requests with req_valid held high: req_ready drops after accept, the second request is accepted only after RESP, and exactly one strobe is issued per request.
- Reset asserted during WAIT of a load: no resp_valid afterward, all RAM outputs 0, req_ready=1 in the first cycle after reset deasserts.
- RD_LAT=1 and RD_LAT=4 builds: load resp_valid at cycle 3 and cycle 6 respectively, data correct.
